// File: rtl/quadra_pkg.sv
// Shared widths, sample/coefficient types and the saturating add used by the
// quadratic interpolation pipeline.
package quadra_pkg;

  localparam int DEF_IDX_W  = 7;
  localparam int DEF_FRAC_W = 16;
  localparam int DEF_A_W    = 22;
  localparam int DEF_B_W    = 16;
  localparam int DEF_C_W    = 8;
  localparam int DEF_SH1    = 10;
  localparam int DEF_SH2    = 10;
  localparam int DEF_TAG_W  = 2;

  typedef logic        [DEF_IDX_W-1:0]  x1_t;
  typedef logic        [DEF_FRAC_W-1:0] x2_t;
  typedef logic signed [DEF_A_W-1:0]    a_t;
  typedef logic signed [DEF_B_W-1:0]    b_t;
  typedef logic signed [DEF_C_W-1:0]    c_t;
  typedef logic        [DEF_TAG_W-1:0]  tag_t;
  typedef logic signed [DEF_A_W-1:0]    y_t;

  // Adds two sign-extended operands and clamps to a w-bit signed range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                 input logic signed [63:0] y,
                                                 input int w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = x + y;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/quadra_coef_ram.sv
// Coefficient table: one write port, one registered read port with enable.
// Contents are deliberately not reset.
module quadra_coef_ram #(
  parameter int IDX_W = 7,
  parameter int D_W   = 46
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [D_W-1:0]   wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [D_W-1:0]   rdata
);

  logic [D_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/quadra_interp_pipe.sv
// Five-stage Horner evaluator y = a + x2*(b + x2*c) with a loadable coefficient
// table, valid/ready on both sides and a tag riding along with each sample.
module quadra_interp_pipe
  import quadra_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int A_W    = DEF_A_W,
  parameter int B_W    = DEF_B_W,
  parameter int C_W    = DEF_C_W,
  parameter int SH1    = DEF_SH1,
  parameter int SH2    = DEF_SH2,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W+FRAC_W-1:0] in_x,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_addr,
  input  logic signed [A_W-1:0]   cfg_a,
  input  logic signed [B_W-1:0]   cfg_b,
  input  logic signed [C_W-1:0]   cfg_c,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [A_W-1:0]   out_y,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int D_W  = A_W + B_W + C_W;
  localparam int P1_W = C_W + FRAC_W + 1;
  localparam int T1_W = P1_W - SH1;
  localparam int T2_W = B_W + 2;
  localparam int P3_W = T2_W + FRAC_W + 1;
  localparam int T3_W = P3_W - SH2;

  logic                 en;
  logic                 rd_en;
  logic [D_W-1:0]       rd_data;
  logic signed [A_W-1:0] a0;
  logic signed [B_W-1:0] b0;
  logic signed [C_W-1:0] c0;

  logic                  v0, v1, v2, v3;
  logic [FRAC_W-1:0]     x2_0, x2_1, x2_2;
  logic [TAG_W-1:0]      tag0, tag1, tag2, tag3;
  logic signed [A_W-1:0] a1, a2, a3;
  logic signed [B_W-1:0] b1;
  logic signed [T1_W-1:0] t1;
  logic signed [T2_W-1:0] t2;
  logic signed [T3_W-1:0] t3;

  // A stalled output freezes the whole pipe; config writes steal the input slot
  // so the table read and write never collide.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en && !cfg_we;
  assign rd_en    = in_valid && in_ready;

  quadra_coef_ram #(
    .IDX_W(IDX_W),
    .D_W  (D_W)
  ) u_coef_ram (
    .clk  (clk),
    .we   (cfg_we),
    .waddr(cfg_addr),
    .wdata({cfg_a, cfg_b, cfg_c}),
    .re   (rd_en),
    .raddr(in_x[IDX_W+FRAC_W-1:FRAC_W]),
    .rdata(rd_data)
  );

  assign {a0, b0, c0} = rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      v0        <= rd_en;
      v1        <= v0;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        out_y   <= A_W'(sat_add(64'(a3), 64'(t3), A_W));
        out_tag <= tag3;
      end
    end
  end

  // Datapath registers carry no reset; their validity is tracked by v0..v3.
  // Products are formed at full width and x2 is zero-extended before use.
  always_ff @(posedge clk) begin
    if (en) begin
      x2_0 <= in_x[FRAC_W-1:0];
      tag0 <= in_tag;

      a1   <= a0;
      b1   <= b0;
      x2_1 <= x2_0;
      tag1 <= tag0;
      t1   <= T1_W'((P1_W'(c0) * P1_W'($signed({1'b0, x2_0}))) >>> SH1);

      a2   <= a1;
      x2_2 <= x2_1;
      tag2 <= tag1;
      t2   <= T2_W'(b1) + T2_W'(t1);

      a3   <= a2;
      tag3 <= tag2;
      t3   <= T3_W'((P3_W'(t2) * P3_W'($signed({1'b0, x2_2}))) >>> SH2);
    end
  end

endmodule

// File: tb/tb_quadra_interp_pipe.sv
// Randomized bench for quadra_interp_pipe against an integer reference model
// kept alongside a shadow copy of the coefficient table.
module tb_quadra_interp_pipe;
  import quadra_pkg::*;

  localparam int IDX_W  = DEF_IDX_W;
  localparam int FRAC_W = DEF_FRAC_W;
  localparam int A_W    = DEF_A_W;
  localparam int B_W    = DEF_B_W;
  localparam int C_W    = DEF_C_W;
  localparam int SH1    = DEF_SH1;
  localparam int SH2    = DEF_SH2;
  localparam int TAG_W  = DEF_TAG_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [IDX_W+FRAC_W-1:0] in_x;
  logic [TAG_W-1:0]        in_tag;
  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_addr;
  logic [A_W-1:0]          cfg_a;
  logic [B_W-1:0]          cfg_b;
  logic [C_W-1:0]          cfg_c;
  logic                    out_valid;
  logic                    out_ready;
  logic [A_W-1:0]          out_y;
  logic [TAG_W-1:0]        out_tag;

  quadra_interp_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_tag   (in_tag),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_a    (cfg_a),
    .cfg_b    (cfg_b),
    .cfg_c    (cfg_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint y;
    int     tag;
    int     cyc;
  } exp_t;

  exp_t   exp_q[$];
  longint sh_a[2**IDX_W];
  longint sh_b[2**IDX_W];
  longint sh_c[2**IDX_W];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic             o_valid, o_fire, i_fire, o_in_ready;
  logic [A_W-1:0]   o_y;
  logic [TAG_W-1:0] o_tag;
  int               o_cyc;

  function automatic longint fdiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint wrap_signed(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r = r + m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint model_y(input int addr, input longint x2);
    longint t1, t2, t3, y, hi, lo;
    t1 = fdiv(sh_c[addr] * x2, longint'(1) << SH1);
    t2 = wrap_signed(sh_b[addr] + t1, B_W + 2);
    t3 = fdiv(t2 * x2, longint'(1) << SH2);
    y  = sh_a[addr] + t3;
    hi = (longint'(1) << (A_W - 1)) - 1;
    lo = -hi - 1;
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
  endfunction

  // One clock: observe at the falling edge, log accepts/writes into the model,
  // then return just after the next rising edge for the caller to drive.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    o_valid    = out_valid;
    o_y        = out_y;
    o_tag      = out_tag;
    o_in_ready = in_ready;
    o_cyc      = cyc;
    o_fire     = out_valid && out_ready && !rst;
    i_fire     = in_valid && in_ready && !rst;
    if (rst) begin
      exp_q.delete();
    end else if (i_fire) begin
      e.y   = model_y(int'(in_x[IDX_W+FRAC_W-1:FRAC_W]), longint'(in_x[FRAC_W-1:0]));
      e.tag = int'(in_tag);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    if (cfg_we) begin
      sh_a[cfg_addr] = longint'($signed(cfg_a));
      sh_b[cfg_addr] = longint'($signed(cfg_b));
      sh_c[cfg_addr] = longint'($signed(cfg_c));
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int addr, input logic [A_W-1:0] a,
                            input logic [B_W-1:0] b, input logic [C_W-1:0] c);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(addr);
    cfg_a    = a;
    cfg_b    = b;
    cfg_c    = c;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++;
    if (o_y !== '0) begin errors++; $display("FAIL reset_y: got %h want 0", o_y); end
    checks++;
    if (o_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0d want 0", o_tag); end
    checks++;
    if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", o_in_ready); end
  endtask

  task automatic test_basic();
    logic got;
    int   acc;
    exp_t e;
    write_coef(5, 22'h012345, 16'h1000, 8'h10);
    in_valid = 1'b1;
    in_x     = {7'd5, 16'h0000};
    in_tag   = 2'd2;
    tick();
    in_valid = 1'b0;
    acc = o_cyc;
    checks++;
    if (i_fire !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", i_fire); end
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (o_fire) begin
        got = 1'b1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (o_y !== 22'h012345) begin errors++; $display("FAIL basic_y: got %h want 012345", o_y); end
        checks++;
        if (o_tag !== 2'd2) begin errors++; $display("FAIL basic_tag: got %0d want 2", o_tag); end
        checks++;
        if (o_cyc - acc !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", o_cyc - acc); end
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL basic_timeout: got no output want one"); end
  endtask

  task automatic test_boundary();
    logic [A_W-1:0]    va [3] = '{22'h000000, 22'h1FFFFF, 22'h200000};
    logic [B_W-1:0]    vb [3] = '{16'h1000, 16'h7FFF, 16'h8000};
    logic [C_W-1:0]    vc [3] = '{8'h00, 8'h7F, 8'h80};
    logic [FRAC_W-1:0] vx [3] = '{16'h8000, 16'hFFFF, 16'hFFFF};
    logic [A_W-1:0]    vy [3] = '{22'h020000, 22'h1FFFFF, 22'h200000};
    int                va_idx [3] = '{0, 1, 1};
    logic got;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      write_coef(va_idx[i], va[i], vb[i], vc[i]);
      in_valid = 1'b1;
      in_x     = {IDX_W'(va_idx[i]), vx[i]};
      in_tag   = TAG_W'(i);
      tick();
      in_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        if (o_fire) begin
          got = 1'b1;
          if (exp_q.size() > 0) e = exp_q.pop_front();
          checks++;
          if (o_y !== vy[i] || o_tag !== TAG_W'(i))
            begin errors++; $display("FAIL boundary_%0d: got y=%h tag=%0d want y=%h tag=%0d", i, o_y, o_tag, vy[i], i); end
        end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL boundary_timeout_%0d: got no output want one", i); end
    end
  endtask

  task automatic test_stream();
    int               sent = 0;
    int               recv = 0;
    logic             prev_stall = 1'b0;
    logic [A_W-1:0]   prev_y = '0;
    logic [TAG_W-1:0] prev_tag = '0;
    exp_t             e;
    for (int i = 8; i < 12; i++)
      write_coef(i, A_W'($urandom), B_W'($urandom), C_W'($urandom));
    in_x = {IDX_W'(8 + $urandom_range(0, 3)), FRAC_W'($urandom)};
    for (int k = 0; k < 400 && (sent < 20 || exp_q.size() > 0); k++) begin
      in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
      in_tag    = TAG_W'(sent % 4);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (prev_stall) begin
        checks++;
        if (o_valid !== 1'b1 || o_y !== prev_y || o_tag !== prev_tag)
          begin errors++; $display("FAIL stream_hold: got v=%b y=%h tag=%0d want v=1 y=%h tag=%0d", o_valid, o_y, o_tag, prev_y, prev_tag); end
      end
      prev_stall = o_valid && !out_ready;
      prev_y     = o_y;
      prev_tag   = o_tag;
      if (i_fire) begin
        sent++;
        in_x = {IDX_W'(8 + $urandom_range(0, 3)), FRAC_W'($urandom)};
      end
      if (o_fire) begin
        recv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got y=%h tag=%0d want no output", o_y, o_tag);
        end else begin
          e = exp_q.pop_front();
          if (longint'($signed(o_y)) !== e.y || int'(o_tag) !== e.tag)
            begin errors++; $display("FAIL stream_data: got y=%0d tag=%0d want y=%0d tag=%0d", $signed(o_y), o_tag, e.y, e.tag); end
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv !== 20) begin errors++; $display("FAIL stream_count: got %0d want 20", recv); end
  endtask

  task automatic test_cfg_midstream();
    int   sent = 0;
    int   recv = 0;
    exp_t e;
    write_coef(3, 22'd1000, 16'h2000, 8'h20);
    in_x = {7'd3, FRAC_W'($urandom)};
    for (int k = 0; k < 200 && (sent < 12 || exp_q.size() > 0); k++) begin
      in_valid  = (sent < 12);
      in_tag    = TAG_W'(sent % 4);
      out_ready = (k < 5 || k > 8);
      cfg_we    = (k == 6);
      cfg_addr  = 7'd3;
      cfg_a     = A_W'(-5000);
      cfg_b     = B_W'(-4096);
      cfg_c     = C_W'(-48);
      tick();
      if (cfg_we) begin
        checks++;
        if (o_in_ready !== 1'b0 || i_fire !== 1'b0)
          begin errors++; $display("FAIL cfg_in_ready: got in_ready=%b accept=%b want 0 0", o_in_ready, i_fire); end
      end
      cfg_we = 1'b0;
      if (i_fire) begin
        sent++;
        in_x = {7'd3, FRAC_W'($urandom)};
      end
      if (o_fire) begin
        recv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL cfg_extra: got y=%h want no output", o_y);
        end else begin
          e = exp_q.pop_front();
          if (longint'($signed(o_y)) !== e.y || int'(o_tag) !== e.tag)
            begin errors++; $display("FAIL cfg_data: got y=%0d tag=%0d want y=%0d tag=%0d", $signed(o_y), o_tag, e.y, e.tag); end
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv !== 12) begin errors++; $display("FAIL cfg_count: got %0d want 12", recv); end
  endtask

  task automatic test_reset_inflight();
    logic                    got;
    logic                    stale;
    exp_t                    e;
    logic [IDX_W+FRAC_W-1:0] probe [3] = '{{7'd5, 16'h1234}, {7'd5, 16'h1234}, {7'd6, 16'hABCD}};
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      if (p == 1) begin
        for (int k = 0; k < 3; k++) begin
          in_valid = 1'b1;
          in_x     = {7'd9, FRAC_W'($urandom)};
          in_tag   = TAG_W'(k);
          tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 7'd6;
        cfg_a    = 22'h0ABCDE;
        cfg_b    = 16'hF000;
        cfg_c    = 8'h40;
        tick();
        rst    = 1'b0;
        cfg_we = 1'b0;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_flush_valid: got %b want 0", o_valid); end
        stale = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tick();
          if (o_valid) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin errors++; $display("FAIL rst_stale: got out_valid=1 want 0"); end
      end
      in_valid = 1'b1;
      in_x     = probe[p];
      in_tag   = TAG_W'(p + 1);
      tick();
      in_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        if (o_fire) begin
          got = 1'b1;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL rst_probe_extra_%0d: got y=%h want no output", p, o_y);
          end else begin
            e = exp_q.pop_front();
            if (longint'($signed(o_y)) !== e.y || int'(o_tag) !== e.tag)
              begin errors++; $display("FAIL rst_probe_%0d: got y=%0d tag=%0d want y=%0d tag=%0d", p, $signed(o_y), o_tag, e.y, e.tag); end
          end
        end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL rst_probe_timeout_%0d: got no output want one", p); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_tag    = '0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_a     = '0;
    cfg_b     = '0;
    cfg_c     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 2**IDX_W; i++) begin
      sh_a[i] = 0;
      sh_b[i] = 0;
      sh_c[i] = 0;
    end
    test_reset();
    test_basic();
    test_boundary();
    test_stream();
    test_cfg_midstream();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quadra_interp_pipe.md
Name: quadra_interp_pipe

Overview:
- Pipelined, parametrised quadratic-interpolation evaluator: y = a + x2·(b + x2·c), Horner form.
- Coefficients (a, b, c) come from a runtime-loadable coefficient RAM indexed by the upper IDX_W bits of the input (x1); x2 is the lower FRAC_W bits.
- Supersedes the fixed combinational coefficient table. Sits between the phase/argument generator and downstream DSP with valid/ready on both sides; a tag travels with each sample for multi-channel use.

Parameters:
- IDX_W, 7: coefficient index width (x1); table depth is 2**IDX_W.
- FRAC_W, 16: unsigned fractional offset width (x2), value in [0,1).
- A_W, 22: signed a width; also output width.
- B_W, 16: signed b width.
- C_W, 8: signed c width.
- SH1, 10: right shift applied to c·x2 to align it to b's LSB.
- SH2, 10: right shift applied to t2·x2 to align it to a's LSB.
- TAG_W, 2: sideband tag width (channel id).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_x  in  IDX_W+FRAC_W  {x1, x2}
- in_tag  in  TAG_W  sideband, returned unchanged with the result
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  IDX_W  coefficient entry
- cfg_a / cfg_b / cfg_c  in  A_W / B_W / C_W  write data, signed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_y  out  A_W  signed result
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset: synchronous, active-high. out_valid=0, out_y=0, out_tag=0, all stage valids=0. In-flight samples are discarded. RAM contents are not reset and survive rst.
- Pipeline (5 stages, each with a valid bit, global enable en = !(out_valid && !out_ready)):
  - S0: registered RAM read of x1; latch x2 and tag.
  - S1: t1 = floor(c·x2 / 2**SH1), with x2 zero-extended and signed multiply.
  - S2: t2 = b + t1, B_W+2 bits, no saturation.
  - S3: t3 = floor(t2·x2 / 2**SH2).
  - S4: y = a + t3, saturated to the A_W signed range. out_y is registered.
- Latency: a sample accepted in cycle N has out_valid=1 in cycle N+5 if there is no backpressure. Throughput is 1 sample/cycle.
- Backpressure: when out_valid && !out_ready, every stage holds, including out_y and out_tag, which stay stable. in_ready = en && !cfg_we (combinational from out_ready and cfg_we). No sample is lost or duplicated.
- Config writes:
  - cfg_we takes effect at the clock edge and is always accepted, including during stalls.
  - in_ready is low while cfg_we is high, so no S0 read coincides with a write.
  - Samples already past S0 use the old coefficients. Samples accepted after the write cycle use the new ones.
- Width rules: all products are full width before shifting. Shifts are arithmetic (floor toward −inf). Only the final add saturates: y > 2**(A_W-1)-1 clamps to max, y < -2**(A_W-1) clamps to min.
- Tags propagate with their samples, in order.
- Simultaneous events: reset has priority over cfg_we and all handshakes. A cfg_we asserted in the same cycle as rst still writes the RAM.

Decomposition:
- quadra.svh / quadra_pkg: x1_t, x2_t, a_t, b_t, c_t, tag_t, y_t derived from the parameters' defaults; a sat_add function; SH1/SH2 default constants.
- Sub-module quadra_coef_ram: 2**IDX_W × (A_W+B_W+C_W), one write port and one registered read port with read enable (= en && in_valid && in_ready).

Test Plan:
1. Load addr 5 with a=0x012345, b=0x1000, c=0x10. Send x1=5, x2=0, tag=2 → out_y=0x012345, out_tag=2, exactly 5 cycles after accept.
2. Load addr 0 with a=0, b=0x1000, c=0. Send x2=0x8000 → t3=0x20000, out_y=0x020000.
3. Load addr 1 with a=0x1FFFFF, b=0x7FFF, c=0x7F. Send x2=0xFFFF → out_y=0x1FFFFF (saturated). With a=0x200000, b=0x8000, c=0x80 → out_y=0x200000.
4. Stream 20 samples with tags 0..3 cycling while out_ready toggles with a random pattern → results arrive in order, tags match, and out_y/out_tag are held stable during every stall.
5. Hold in_valid=1, pulse cfg_we on addr 3 mid-stream → in_ready=0 during the write cycle. Samples accepted before the write show old coefficients; samples after show new ones.
6. Assert rst for 1 cycle with 3 samples in flight → out_valid=0 the next cycle and no stale outputs appear. RAM entries are unchanged: a re-sent sample gives the same out_y as before the reset.
